// File: rtl/panda_div_if.sv
// Bus bundle for the pulse divider: pulse input, control registers and status readback.
// The master drives the pulse and control fields; the divider (slave) drives the outputs.
interface panda_div_if #(
   parameter int CW = 32
);
   logic          inp_i;
   logic          enable_i;
   logic [CW-1:0] DIVISOR;
   logic          FIRST_PULSE;
   logic          outd_o;
   logic          outn_o;
   logic [CW-1:0] COUNT;

   modport master (
      output inp_i, enable_i, DIVISOR, FIRST_PULSE,
      input  outd_o, outn_o, COUNT
   );

   modport slave (
      input  inp_i, enable_i, DIVISOR, FIRST_PULSE,
      output outd_o, outn_o, COUNT
   );
endinterface

// File: rtl/panda_div.sv
// Pulse divider: counts rising edges of inp_i and steers every D-th pulse to outd_o,
// the rest to outn_o, mirroring the input pulse one clock late on the chosen output.
module panda_div #(
   parameter int CW = 32
) (
   input  logic       clk_i,
   input  logic       reset_i,
   panda_div_if.slave bus
);
   typedef enum logic [1:0] {
      ROUTE_NONE,
      ROUTE_OUTN,
      ROUTE_OUTD
   } route_e;

   route_e        route_q, route_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] divisor_q;
   logic          firstPulse_q;
   logic          inpPrev_q;
   logic          outd_q, outd_d;
   logic          outn_q, outn_d;

   logic [CW-1:0] divEff;
   logic [CW-1:0] divMax;
   logic [CW-1:0] reloadVal;
   logic          rise;
   logic          reload;

   // Any control change forces a reload, so the counter can never sit above D-1.
   always_comb begin
      divEff    = (bus.DIVISOR == '0) ? CW'(1) : bus.DIVISOR;
      divMax    = divEff - CW'(1);
      reloadVal = bus.FIRST_PULSE ? divMax : '0;
      rise      = bus.inp_i & ~inpPrev_q;
      reload    = reset_i | ~bus.enable_i |
                  (bus.DIVISOR != divisor_q) | (bus.FIRST_PULSE != firstPulse_q);
   end

   always_comb begin
      route_d = route_q;
      count_d = count_q;
      if (reload) begin
         route_d = ROUTE_NONE;
         count_d = reloadVal;
      end else if (rise) begin
         if (count_q == divMax) begin
            route_d = ROUTE_OUTD;
            count_d = '0;
         end else begin
            route_d = ROUTE_OUTN;
            count_d = count_q + CW'(1);
         end
      end else if (!bus.inp_i) begin
         route_d = ROUTE_NONE;
      end
   end

   always_comb begin
      outd_d = bus.inp_i && (route_d == ROUTE_OUTD);
      outn_d = bus.inp_i && (route_d == ROUTE_OUTN);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         route_q      <= ROUTE_NONE;
         count_q      <= reloadVal;
         divisor_q    <= bus.DIVISOR;
         firstPulse_q <= bus.FIRST_PULSE;
         inpPrev_q    <= 1'b0;
         outd_q       <= 1'b0;
         outn_q       <= 1'b0;
      end else begin
         route_q      <= route_d;
         count_q      <= count_d;
         divisor_q    <= bus.DIVISOR;
         firstPulse_q <= bus.FIRST_PULSE;
         inpPrev_q    <= bus.inp_i;
         outd_q       <= outd_d;
         outn_q       <= outn_d;
      end
   end

   assign bus.outd_o = outd_q;
   assign bus.outn_o = outn_q;
   assign bus.COUNT  = count_q;
endmodule

// File: tb/tb_panda_div.sv
// Directed testbench for panda_div: table of single-pulse vectors plus hand-written
// sequences for long pulses, enable drop, divisor change and mid-pulse reset.
module tb_panda_div;
   logic clk;
   logic reset;

   panda_div_if #(.CW(32)) bus ();

   panda_div #(.CW(32)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [31:0] divisor;
      logic        firstPulse;
      logic        expOutd;
      logic        expOutn;
      logic [31:0] expCount;
   } vec_t;

   vec_t vecs [16];
   int   passChecks;
   int   totalChecks;
   logic [31:0] curDiv;
   logic        curFp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic expD, input logic expN,
                              input logic [31:0] expC);
      totalChecks++;
      if (bus.outd_o === expD && bus.outn_o === expN && bus.COUNT === expC) begin
         passChecks++;
      end else begin
         $display("[TB] FAIL %s: got outd=%0b outn=%0b count=%0d, expected outd=%0b outn=%0b count=%0d",
                  name, bus.outd_o, bus.outn_o, bus.COUNT, expD, expN, expC);
      end
   endtask

   // One-clock pulse followed by three idle clocks; output must track one clock late.
   task automatic applyStimulus(input string name, input logic expD, input logic expN,
                                input logic [31:0] expC);
      bus.inp_i = 1'b1;
      tick();
      checkOutput(name, expD, expN, expC);
      bus.inp_i = 1'b0;
      tick();
      checkOutput({name, "_end"}, 1'b0, 1'b0, expC);
      tick();
      tick();
   endtask

   task automatic setConfig(input logic [31:0] d, input logic fp);
      logic [31:0] expReload;
      if (d != curDiv || fp != curFp) begin
         bus.DIVISOR     = d;
         bus.FIRST_PULSE = fp;
         curDiv = d;
         curFp  = fp;
         expReload = fp ? ((d == 0) ? 32'd0 : d - 32'd1) : 32'd0;
         tick();
         tick();
         checkOutput($sformatf("reload_d%0d_fp%0b", d, fp), 1'b0, 1'b0, expReload);
      end
   endtask

   initial begin
      passChecks  = 0;
      totalChecks = 0;

      vecs[0]  = '{32'd3, 1'b0, 1'b0, 1'b1, 32'd1};
      vecs[1]  = '{32'd3, 1'b0, 1'b0, 1'b1, 32'd2};
      vecs[2]  = '{32'd3, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[3]  = '{32'd3, 1'b0, 1'b0, 1'b1, 32'd1};
      vecs[4]  = '{32'd3, 1'b0, 1'b0, 1'b1, 32'd2};
      vecs[5]  = '{32'd3, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[6]  = '{32'd3, 1'b1, 1'b1, 1'b0, 32'd0};
      vecs[7]  = '{32'd3, 1'b1, 1'b0, 1'b1, 32'd1};
      vecs[8]  = '{32'd3, 1'b1, 1'b0, 1'b1, 32'd2};
      vecs[9]  = '{32'd3, 1'b1, 1'b1, 1'b0, 32'd0};
      vecs[10] = '{32'd0, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[11] = '{32'd0, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[12] = '{32'd0, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[13] = '{32'd1, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[14] = '{32'd1, 1'b0, 1'b1, 1'b0, 32'd0};
      vecs[15] = '{32'd1, 1'b0, 1'b1, 1'b0, 32'd0};

      reset           = 1'b1;
      bus.inp_i       = 1'b0;
      bus.enable_i    = 1'b1;
      bus.DIVISOR     = 32'd3;
      bus.FIRST_PULSE = 1'b0;
      curDiv = 32'd3;
      curFp  = 1'b0;
      tick();
      tick();
      checkOutput("reset_state", 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 16; i++) begin
         setConfig(vecs[i].divisor, vecs[i].firstPulse);
         applyStimulus($sformatf("vec%0d", i), vecs[i].expOutd, vecs[i].expOutn, vecs[i].expCount);
      end

      // Five-clock pulses with D=2, FIRST_PULSE=1: first on outd, second on outn.
      setConfig(32'd2, 1'b1);
      bus.inp_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("long_outd_%0d", i), 1'b1, 1'b0, 32'd0);
      end
      bus.inp_i = 1'b0;
      tick();
      checkOutput("long_outd_fall", 1'b0, 1'b0, 32'd0);
      tick();
      bus.inp_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("long_outn_%0d", i), 1'b0, 1'b1, 32'd1);
      end
      bus.inp_i = 1'b0;
      tick();
      checkOutput("long_outn_fall", 1'b0, 1'b0, 32'd1);
      tick();

      // Enable dropped on the third cycle of a six-clock pulse, then re-enabled while high.
      setConfig(32'd3, 1'b0);
      bus.inp_i = 1'b1;
      tick();
      checkOutput("en_pulse_c1", 1'b0, 1'b1, 32'd1);
      tick();
      checkOutput("en_pulse_c2", 1'b0, 1'b1, 32'd1);
      bus.enable_i = 1'b0;
      tick();
      checkOutput("en_drop", 1'b0, 1'b0, 32'd0);
      bus.enable_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("en_reenable_%0d", i), 1'b0, 1'b0, 32'd0);
      end
      bus.inp_i = 1'b0;
      tick();
      tick();
      applyStimulus("en_next_edge", 1'b0, 1'b1, 32'd1);

      // DIVISOR 4 -> 2 on the same clock as a rise: that pulse is dropped.
      setConfig(32'd4, 1'b0);
      applyStimulus("d4_pulse", 1'b0, 1'b1, 32'd1);
      bus.DIVISOR = 32'd2;
      curDiv      = 32'd2;
      bus.inp_i   = 1'b1;
      tick();
      checkOutput("divchg_drop_c1", 1'b0, 1'b0, 32'd0);
      tick();
      checkOutput("divchg_drop_c2", 1'b0, 1'b0, 32'd0);
      bus.inp_i = 1'b0;
      tick();
      checkOutput("divchg_drop_end", 1'b0, 1'b0, 32'd0);
      tick();
      applyStimulus("d2_p1", 1'b0, 1'b1, 32'd1);
      applyStimulus("d2_p2", 1'b1, 1'b0, 32'd0);
      applyStimulus("d2_p3", 1'b0, 1'b1, 32'd1);

      // Reset asserted in the middle of an outd pulse.
      bus.inp_i = 1'b1;
      tick();
      checkOutput("rst_pulse", 1'b1, 1'b0, 32'd0);
      reset = 1'b1;
      tick();
      checkOutput("rst_mid", 1'b0, 1'b0, 32'd0);
      bus.inp_i = 1'b0;
      tick();
      checkOutput("rst_hold", 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      tick();
      checkOutput("rst_release", 1'b0, 1'b0, 32'd0);
      applyStimulus("rst_after", 1'b0, 1'b1, 32'd1);

      $display("%0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end
endmodule

// File: doc/panda_div.md
Name: panda_div

Overview:
- Pulse divider that sits directly downstream of the LUT stage.
- Consumes a single-bit logic output such as the LUT `out_o` and counts its rising edges.
- Steers every DIVISOR-th input pulse to `outd_o`; all other pulses go to `outn_o`.
- Register-controlled through DIVISOR and FIRST_PULSE, with COUNT read back as status.

Parameters:
- CW, 32, width of the DIVISOR register and of the internal counter/COUNT.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- inp_i  in  1  pulse input (e.g. the LUT output).
- enable_i  in  1  level enable; low holds the block idle and reloads the counter.
- DIVISOR  in  CW  divide ratio; 0 and 1 are both treated as 1.
- FIRST_PULSE  in  1  0 = first pulse after reload goes to outn_o; 1 = first pulse goes to outd_o.
- outd_o  out  1  divided pulse output.
- outn_o  out  1  non-divided (remainder) pulse output.
- COUNT  out  CW  current counter value (status readback).

Behaviour:
- Clock and reset: one clock, `clk_i`. `reset_i` is synchronous and active-high.
- Reset values: outd_o=0, outn_o=0, COUNT=reload value, inp_prev=0, route=NONE.
- Effective divisor: D = max(DIVISOR,1).
- Reload value:
  - FIRST_PULSE=1: D-1.
  - FIRST_PULSE=0: 0.
- Edge detect: rise = inp_i & ~inp_prev, where inp_prev is registered every cycle.
- Reload condition, evaluated each cycle: reset_i, or enable_i=0, or DIVISOR or FIRST_PULSE differs from its registered copy of the previous cycle.
  - On reload: counter ← reload value, route ← NONE, both outputs 0 next cycle.
  - A rise in a reload cycle is dropped; that whole input pulse produces no output.
- Counting, on a rise with enable_i=1 and no reload:
  - If counter == D-1: route ← OUTD, counter ← 0.
  - Otherwise: route ← OUTN, counter ← counter+1.
- Output mirroring: while route≠NONE, the selected output equals inp_i delayed by exactly one clock; the other output is 0.
  - route returns to NONE on the cycle inp_i is sampled low.
  - Output pulse width therefore equals input pulse width.
  - Latency from inp_i rise to output rise is 1 clk.
- Single-cycle input pulses give single-cycle output pulses.
- Back-to-back pulses (inp 1,0,1) are each counted and routed independently.
- enable_i falling mid-pulse: the active output drops to 0 the next cycle. Re-enabling while inp_i is still high does not create an edge.
- Counter wrap:
  - The counter never exceeds D-1.
  - If DIVISOR is reduced below the current counter value, the change triggers a reload, so no out-of-range state exists.
- COUNT: registered counter value, updated the same cycle as the counter; it reflects the post-edge value one clk after the rise.
- outd_o and outn_o are never high in the same cycle.

Test Plan:
- Reset, DIVISOR=3, FIRST_PULSE=0, enable=1; 6 one-cycle pulses spaced 4 clk → routing outn, outn, outd, outn, outn, outd, each output 1 clk after input; COUNT sequence 1,2,0,1,2,0.
- DIVISOR=3, FIRST_PULSE=1, enable=1; 4 pulses → routing outd, outn, outn, outd; COUNT 0,1,2,0 after reload value 2.
- DIVISOR=0, then DIVISOR=1; 3 pulses at each setting → all pulses on outd_o, outn_o stays 0, COUNT stays 0.
- Input held high 5 clk with DIVISOR=2, FIRST_PULSE=1 → outd_o high exactly 5 clk, starting 1 clk after the rise; second 5-clk pulse → outn_o high 5 clk.
- enable dropped on the 3rd cycle of a 6-clk pulse → output falls 1 clk later; COUNT returns to reload value; re-enable with inp_i still high → no output until the next rising edge.
- Change DIVISOR 4→2 coincident with a rise → that pulse dropped (no output), COUNT=reload; the next pulses follow the D=2 pattern. Also assert reset_i mid-pulse → outputs 0 next cycle.
